dodge_round_ctrl: RTL
=====================

# dodge_round_ctrl

Round controller for the dodge game. It sequences one play round: start, falling-obstacle scheduling, a per-second round timer, and ending in either fail (collision) or gameover (timer expiry).
- It drives per-lane step and clear pulses into the falling-square datapath.
- It decides which lane spawns an obstacle, and owns the step rate (optionally ramping up).
- It sits between the keyboard scan-code decode (start/restart pulses) and the square/bar renderers; its `seconds` output feeds the 7-segment decoders.

## Interface
Parameters:
- `CLK_HZ`, 50000000, clock cycles per round-timer second
- `LANES`, 4, number of obstacle lanes; must be a power of 2, range 2..8
- `ROUND_SECS`, 30, round length in seconds, range 1..255
- `BASE_PERIOD`, 500000, initial cycles between step pulses
- `MIN_PERIOD`, 100000, floor for the step period
- `PERIOD_DEC`, 50000, period decrement applied per elapsed second
- `SPAWN_STEPS`, 60, step ticks between spawn attempts

Ports (clock and reset first):
- `clk` in 1: single clock (CLOCK_50 domain).
- `reset` in 1: asynchronous, active-high reset.
- `start_key` in 1: one-cycle pulse (Enter decoded); starts or restarts a round.
- `restart_key` in 1: one-cycle pulse (Space decoded); returns the block to IDLE.
- `hit` in 1: level; player/obstacle collision.
- `lane_bottom` in LANES: one-cycle pulse per lane; that lane's obstacle reached row 600.
- `lane_step` out LANES: one-cycle pulse; advance that lane's obstacle one row.
- `lane_clear` out LANES: one-cycle pulse; return that lane's obstacle to rows 0..60.
- `lane_active` out LANES: level; the lane currently holds a falling obstacle.
- `seconds` out 8: elapsed round seconds.
- `state` out 2: IDLE=0, PLAY=1, FAIL=2, DONE=3.
- `fail` out 1: high while `state` is FAIL.
- `gameover` out 1: high while `state` is DONE.

## Operation
State machine:
- IDLE: `start_key` goes to PLAY.
- PLAY:
  - `hit` goes to FAIL.
  - `seconds == ROUND_SECS` goes to DONE.
  - `restart_key` goes to IDLE.
  - `hit` and timeout in the same cycle: FAIL wins.
- FAIL and DONE:
  - `start_key` goes to PLAY.
  - `restart_key` goes to IDLE.
  - `start_key` and `restart_key` in the same cycle: IDLE wins, in every state.

Entry to PLAY (from any state):
- `seconds`, the second counter, the step counter and the spawn counter are cleared.
- `step_period` is set to `BASE_PERIOD`.
- `lane_active` is set to 0.
- `lane_clear` pulses all-ones for one cycle.

Entry to IDLE:
- Same clears as entry to PLAY, but no `lane_clear` pulse.

Round timer:
- Counts cycles only in PLAY.
- Every `CLK_HZ` cycles, `seconds` increments.
- `seconds` saturates at `ROUND_SECS`.
- `seconds` is frozen in FAIL and DONE.

Step scheduler (PLAY only):
- The step counter reloads to `step_period`.
- On terminal count, `lane_step` pulses exactly the bits set in `lane_active`, and the spawn counter increments.

Spawn:
- When the spawn counter reaches `SPAWN_STEPS`, it resets and `lane = lfsr[log2(LANES)-1:0]`.
- If that lane is inactive: set its `lane_active` bit and pulse its `lane_clear` bit.
- If that lane is active: the spawn attempt is skipped, with no retry.

LFSR:
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
- Seed 8'hA5.
- Shifts every cycle in every state.

Lane bottom:
- In PLAY, `lane_bottom[i]` clears `lane_active[i]` and pulses `lane_clear[i]`.
- If a spawn targets the same lane in the same cycle, bottom wins and the spawn is skipped.
- `lane_bottom` is ignored outside PLAY.

Outside PLAY:
- `lane_step` is 0.
- `lane_active` holds its last value in FAIL and DONE.

## Timing
- All outputs are registered.
- Reset value of every output is 0; `state` resets to IDLE.
- Internal reset values: LFSR = 8'hA5, `step_period = BASE_PERIOD`, all counters 0.
- Reset is asynchronous: assertion forces reset values immediately, including mid-PLAY.
- Latency:
  - `start_key` to `state == PLAY` and the `lane_clear` pulse: 1 cycle.
  - `hit` to `fail`: 1 cycle.
- First `lane_step` occurs `step_period` cycles after PLAY entry.
- A new `step_period` takes effect at the next reload; the interval in progress is not truncated.
- Spawn and bottom `lane_clear` pulses are issued in the cycle after the triggering event.
- Arithmetic widths:
  - Period, step and second counters: 32 bits.
  - Spawn counter: 16 bits.
  - Period decrement: `step_period = max(step_period - PERIOD_DEC, MIN_PERIOD)`, computed without underflow.

## Configuration
- `DODGE_SPEEDUP_EN` defined: on each `seconds` increment, `step_period` decrements as described above.
- `DODGE_SPEEDUP_EN` undefined: `step_period` is the constant `BASE_PERIOD`; the decrement logic is not built.

## Structure
- Shared package `dodge_pkg`:
  - state encoding constants `ST_IDLE`, `ST_PLAY`, `ST_FAIL`, `ST_DONE`;
  - `LFSR_SEED`;
  - the ENTER/SPACE scan-code constants (8'h5A / 8'h29), used by the top level to form `start_key` and `restart_key`.
- One sub-module, `dodge_lfsr8`: seedable 8-bit LFSR with enable.
- FSM, counters and lane logic stay in `dodge_round_ctrl`.

## Test plan
All scenarios use `CLK_HZ=20`, `LANES=4`, `ROUND_SECS=5`, `BASE_PERIOD=8`, `MIN_PERIOD=4`, `PERIOD_DEC=2`, `SPAWN_STEPS=2`.

1. Release reset, then pulse `start_key` at cycle 3.
   - After reset: all outputs 0, `state=0`.
   - At cycle 4: `state=1` and `lane_clear=4'hF` for one cycle.
2. Run PLAY with `hit` held 0.
   - `seconds` steps every 20 cycles.
   - 100 cycles after entry: `state=3`, `gameover=1`, `seconds=5`, held.
   - `start_key` then re-enters PLAY with `seconds=0`.
3. Assert `hit` 50 cycles into PLAY.
   - Next cycle: `state=2`, `fail=1`, `seconds=2` frozen, `lane_step` stays 0.
   - Second case: assert `hit` in the same cycle as timeout; result must be FAIL.
4. Measure `lane_step` tick spacing with the macro defined.
   - Spacing is 8 until second 1, then 6, then 4, and stays 4.
   - With the macro undefined, spacing is always 8.
5. Observe the second step tick.
   - The lane at `lfsr[1:0]` gets `lane_active` set plus a `lane_clear` pulse.
   - A `lane_bottom` pulse on that lane clears its active bit and pulses `lane_clear` the next cycle.
   - A spawn targeting an occupied lane is skipped.
6. Assert `reset` mid-PLAY, asynchronously between clock edges.
   - All outputs go to 0 and `state=0` before the next edge.
   - After release, `start_key` starts a clean round.

Source files
------------

// File: rtl/dodge_pkg.sv
// Shared constants for the dodge game: FSM state encoding, LFSR seed and the
// PS/2 scan codes that the game top decodes into start/restart pulses.
package dodge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_FAIL = 2'd2,
      ST_DONE = 2'd3
   } dodge_state_e;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_SPACE = 8'h29;

   // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/dodge_lfsr8.sv
// Seedable 8-bit Fibonacci LFSR with enable; a synchronous load overrides the shift.
module dodge_lfsr8
   import dodge_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic       i_load,
   input  logic [7:0] i_seed,
   output logic [7:0] o_value
);

   logic [7:0] r_value;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value <= SEED;
      end else if (i_load) begin
         r_value <= i_seed;
      end else if (i_en) begin
         r_value <= lfsr8_next(r_value);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/dodge_round_ctrl.sv
// Dodge round controller: round FSM, per-second timer, step scheduler and lane spawning.
// Optional step-rate ramp is built when DODGE_SPEEDUP_EN is defined.
module dodge_round_ctrl
   import dodge_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned LANES       = 4,
   parameter int unsigned ROUND_SECS  = 30,
   parameter int unsigned BASE_PERIOD = 500000,
   parameter int unsigned MIN_PERIOD  = 100000,
   parameter int unsigned PERIOD_DEC  = 50000,
   parameter int unsigned SPAWN_STEPS = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_key,
   input  logic             restart_key,
   input  logic             hit,
   input  logic [LANES-1:0] lane_bottom,
   output logic [LANES-1:0] lane_step,
   output logic [LANES-1:0] lane_clear,
   output logic [LANES-1:0] lane_active,
   output logic [7:0]       seconds,
   output logic [1:0]       state,
   output logic             fail,
   output logic             gameover
);

   localparam int unsigned LANE_W    = $clog2(LANES);
   localparam logic [31:0] SEC_LAST  = 32'(CLK_HZ - 1);
   localparam logic [7:0]  SECS_MAX  = 8'(ROUND_SECS);
   localparam logic [31:0] PER_BASE  = 32'(BASE_PERIOD);
   localparam logic [15:0] SPAWN_MAX = 16'(SPAWN_STEPS);

   dodge_state_e     r_state, w_state_d;
   logic [31:0]      r_sec_cnt, w_sec_cnt_d;
   logic [7:0]       r_seconds, w_seconds_d;
   logic [31:0]      r_period, w_period_d;
   logic [31:0]      r_step_len, w_step_len_d;
   logic [31:0]      r_step_cnt, w_step_cnt_d;
   logic [15:0]      r_spawn_cnt, w_spawn_cnt_d;
   logic [LANES-1:0] r_active, w_active_d;
   logic [LANES-1:0] r_step, w_step_d;
   logic [LANES-1:0] r_clear, w_clear_d;
   logic [LANES-1:0] w_spawn_lane, w_spawn_hit;
   logic             r_fail, r_gameover;
   logic [7:0]       w_lfsr;
   logic             w_play, w_run, w_enter_play, w_sec_tick, w_timeout;
   logic             w_step_term, w_spawn_due;
   logic             w_unused;

   dodge_lfsr8 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .i_en   (1'b1),
      .i_load (1'b0),
      .i_seed (LFSR_SEED),
      .o_value(w_lfsr)
   );

   assign w_unused = ^{w_lfsr[7:LANE_W], 32'(MIN_PERIOD), 32'(PERIOD_DEC)};

   assign w_play       = (r_state == ST_PLAY);
   assign w_sec_tick   = w_play && (r_sec_cnt == SEC_LAST);
   // Look ahead so DONE is entered on the same edge seconds reaches its limit.
   assign w_timeout    = (r_seconds == SECS_MAX) ||
                         (w_sec_tick && ((r_seconds + 8'd1) == SECS_MAX));
   assign w_enter_play = (w_state_d == ST_PLAY) && !w_play;
   assign w_run        = w_play && (w_state_d == ST_PLAY);
   assign w_step_term  = (r_step_cnt == (r_step_len - 32'd1));
   assign w_spawn_due  = (r_spawn_cnt == SPAWN_MAX);

`ifdef DODGE_SPEEDUP_EN
   localparam logic [31:0] PER_MIN = 32'(MIN_PERIOD);
   localparam logic [31:0] PER_DEC = 32'(PERIOD_DEC);
   logic [31:0] w_period_dec;
   assign w_period_dec = ((r_period > PER_MIN) && ((r_period - PER_MIN) >= PER_DEC)) ?
                         (r_period - PER_DEC) : PER_MIN;
`endif

   always_comb begin
      w_state_d = r_state;
      if (restart_key) begin
         w_state_d = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:          if (start_key) w_state_d = ST_PLAY;
            ST_PLAY: begin
               if (hit)            w_state_d = ST_FAIL;
               else if (w_timeout) w_state_d = ST_DONE;
            end
            ST_FAIL, ST_DONE: if (start_key) w_state_d = ST_PLAY;
            default:          w_state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_spawn_lane = '0;
      w_spawn_lane[w_lfsr[LANE_W-1:0]] = 1'b1;
      // A bottom event on the chosen lane wins over the spawn.
      w_spawn_hit = '0;
      if (w_spawn_due && !(|(w_spawn_lane & (r_active | lane_bottom)))) begin
         w_spawn_hit = w_spawn_lane;
      end
   end

   always_comb begin
      w_sec_cnt_d   = r_sec_cnt;
      w_seconds_d   = r_seconds;
      w_period_d    = r_period;
      w_step_len_d  = r_step_len;
      w_step_cnt_d  = r_step_cnt;
      w_spawn_cnt_d = r_spawn_cnt;
      w_active_d    = r_active;
      w_step_d      = '0;
      w_clear_d     = '0;
      if ((w_state_d == ST_IDLE) || w_enter_play) begin
         w_sec_cnt_d   = '0;
         w_seconds_d   = '0;
         w_period_d    = PER_BASE;
         w_step_len_d  = PER_BASE;
         w_step_cnt_d  = '0;
         w_spawn_cnt_d = '0;
         w_active_d    = '0;
         if (w_enter_play) w_clear_d = '1;
      end else if (w_play) begin
         if (w_sec_tick) begin
            w_sec_cnt_d = '0;
            if (r_seconds != SECS_MAX) begin
               w_seconds_d = r_seconds + 8'd1;
`ifdef DODGE_SPEEDUP_EN
               w_period_d  = w_period_dec;
`endif
            end
         end else begin
            w_sec_cnt_d = r_sec_cnt + 32'd1;
         end
         if (w_run) begin
            w_active_d    = (r_active & ~lane_bottom) | w_spawn_hit;
            w_clear_d     = lane_bottom | w_spawn_hit;
            w_spawn_cnt_d = w_spawn_due ? 16'd0 : r_spawn_cnt;
            if (w_step_term) begin
               // The running interval completes; a new period applies from here on.
               w_step_cnt_d  = '0;
               w_step_len_d  = r_period;
               w_step_d      = r_active;
               w_spawn_cnt_d = w_spawn_cnt_d + 16'd1;
            end else begin
               w_step_cnt_d = r_step_cnt + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sec_cnt   <= '0;
         r_seconds   <= '0;
         r_period    <= PER_BASE;
         r_step_len  <= PER_BASE;
         r_step_cnt  <= '0;
         r_spawn_cnt <= '0;
         r_active    <= '0;
         r_step      <= '0;
         r_clear     <= '0;
         r_fail      <= 1'b0;
         r_gameover  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_sec_cnt   <= w_sec_cnt_d;
         r_seconds   <= w_seconds_d;
         r_period    <= w_period_d;
         r_step_len  <= w_step_len_d;
         r_step_cnt  <= w_step_cnt_d;
         r_spawn_cnt <= w_spawn_cnt_d;
         r_active    <= w_active_d;
         r_step      <= w_step_d;
         r_clear     <= w_clear_d;
         r_fail      <= (w_state_d == ST_FAIL);
         r_gameover  <= (w_state_d == ST_DONE);
      end
   end

   assign state       = r_state;
   assign fail        = r_fail;
   assign gameover    = r_gameover;
   assign seconds     = r_seconds;
   assign lane_step   = r_step;
   assign lane_clear  = r_clear;
   assign lane_active = r_active;

endmodule
